bus_interconnect: RTL and testbench



---
 rtl/xctcmsg_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 53 +++++
 rtl/bus_interconnect.sv | 118 +++++++++++
 tb/tb_bus_interconnect.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xctcmsg_pkg.sv
// Shared message-network types: bus field widths, the in-flight transfer
// record and the delivery buffer state encoding.
package xctcmsg_pkg;

  localparam int BUS_ADDR_W = 32;
  localparam int BUS_TAG_W  = 32;
  localparam int BUS_MSG_W  = 64;

  // One message held by the interconnect between accept and delivery.
  // Indices are kept at address width so the source can be driven out
  // zero-extended with no further formatting.
  typedef struct packed {
    logic [BUS_ADDR_W-1:0] dst_idx;
    logic [BUS_ADDR_W-1:0] src_idx;
    logic [BUS_TAG_W-1:0]  tag;
    logic [BUS_MSG_W-1:0]  msg;
  } bus_xfer_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// only while advance is high, and moves the pointer past the winner.
module rr_arbiter #(
  parameter int NODES = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NODES-1:0]                       req,
  input  logic                                   advance,
  output logic [NODES-1:0]                       grant,
  output logic [((NODES > 1) ? $clog2(NODES) : 1)-1:0] grant_idx,
  output logic                                   any_grant
);

  localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;

  logic [IDX_W-1:0] ptr_reg;
  logic [IDX_W-1:0] ptr_next;

  // Priority scan starting at the pointer, wrapping past the last node.
  always_comb begin
    int unsigned k;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    k         = 0;
    for (int i = 0; i < NODES; i++) begin
      k = int'(ptr_reg) + i;
      if (k >= NODES) k = k - NODES;
      if (advance && !any_grant && req[k]) begin
        any_grant = 1'b1;
        grant_idx = IDX_W'(k);
      end
    end
    if (any_grant) grant = NODES'(1) << grant_idx;
  end

  // Next pointer is one past the winner, wrapping to node 0.
  always_comb begin
    ptr_next = ptr_reg;
    if (any_grant) begin
      if (grant_idx == IDX_W'(NODES - 1)) ptr_next = '0;
      else                                ptr_next = grant_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk) begin
    if (rst) ptr_reg <= '0;
    else     ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/bus_interconnect.sv
// Shared-bus message switch: arbitrates sender adapters round-robin, holds
// one message in flight and delivers it to the addressed receiver with the
// sender index stamped as source. Out-of-range destinations are acked and
// counted as drops.
module bus_interconnect
  import xctcmsg_pkg::*;
#(
  parameter int NODES      = 4,
  parameter int DROP_CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NODES-1:0]            snd_val_i,
  output logic [NODES-1:0]            snd_ack_o,
  input  logic [NODES*BUS_ADDR_W-1:0] snd_dst_i,
  input  logic [NODES*BUS_TAG_W-1:0]  snd_tag_i,
  input  logic [NODES*BUS_MSG_W-1:0]  snd_msg_i,
  output logic [NODES-1:0]            rcv_val_o,
  input  logic [NODES-1:0]            rcv_rdy_i,
  output logic [BUS_ADDR_W-1:0]       rcv_src_o,
  output logic [BUS_TAG_W-1:0]        rcv_tag_o,
  output logic [BUS_MSG_W-1:0]        rcv_msg_o,
  output logic [DROP_CNT_W-1:0]       drop_count_o
);

  localparam int IDX_W = (NODES > 1) ? $clog2(NODES) : 1;

  buf_state_e            state_reg;
  buf_state_e            state_next;
  bus_xfer_t             buf_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_reg;

  logic                  drain;
  logic                  can_accept;
  logic [NODES-1:0]      grant;
  logic [IDX_W-1:0]      grant_idx;
  logic                  any_grant;
  logic [BUS_ADDR_W-1:0] sel_dst;
  logic [BUS_TAG_W-1:0]  sel_tag;
  logic [BUS_MSG_W-1:0]  sel_msg;
  logic                  load_ok;

  // A held message leaves when its destination is ready; that frees the
  // slot for a new grant in the very same cycle.
  assign drain      = |(rcv_val_o & rcv_rdy_i);
  assign can_accept = (state_reg == BUF_EMPTY) || drain;

  rr_arbiter #(
    .NODES (NODES)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (snd_val_i),
    .advance   (can_accept),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  assign snd_ack_o = grant;
  assign sel_dst   = snd_dst_i[int'(grant_idx)*BUS_ADDR_W +: BUS_ADDR_W];
  assign sel_tag   = snd_tag_i[int'(grant_idx)*BUS_TAG_W +: BUS_TAG_W];
  assign sel_msg   = snd_msg_i[int'(grant_idx)*BUS_MSG_W +: BUS_MSG_W];
  assign load_ok   = any_grant && (sel_dst < BUS_ADDR_W'(NODES));

  // Buffer occupancy state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= BUF_EMPTY;
    else     state_reg <= state_next;
  end

  // Fill on a routable grant, empty on a drain that is not refilled.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BUF_EMPTY: if (load_ok)            state_next = BUF_FULL;
      BUF_FULL:  if (drain && !load_ok)  state_next = BUF_EMPTY;
      default:                           state_next = BUF_EMPTY;
    endcase
  end

  // Delivery valid is the one-hot of the held destination while full.
  always_comb begin
    rcv_val_o = '0;
    for (int i = 0; i < NODES; i++) begin
      rcv_val_o[i] = (state_reg == BUF_FULL) &&
                     (buf_reg.dst_idx == BUS_ADDR_W'(i));
    end
  end

  // Message payload register; holds its content until the next load.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_reg <= '0;
    end else if (load_ok) begin
      buf_reg.dst_idx <= sel_dst;
      buf_reg.src_idx <= BUS_ADDR_W'(grant_idx);
      buf_reg.tag     <= sel_tag;
      buf_reg.msg     <= sel_msg;
    end
  end

  // Saturating count of messages acked but discarded as unroutable.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_reg <= '0;
    end else if (any_grant && !load_ok &&
                 (drop_cnt_reg != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_reg <= drop_cnt_reg + 1'b1;
    end
  end

  assign rcv_src_o    = buf_reg.src_idx;
  assign rcv_tag_o    = buf_reg.tag;
  assign rcv_msg_o    = buf_reg.msg;
  assign drop_count_o = drop_cnt_reg;

endmodule

// File: tb/tb_bus_interconnect.sv
// Bench for bus_interconnect: directed scenarios plus a random phase, all
// checked every cycle against a message-level reference model.
module tb_bus_interconnect;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   snd_val;
  logic [N-1:0]   snd_ack;
  logic [31:0]    d_dst [N];
  logic [31:0]    d_tag [N];
  logic [63:0]    d_msg [N];
  logic [N*32-1:0] snd_dst_flat;
  logic [N*32-1:0] snd_tag_flat;
  logic [N*64-1:0] snd_msg_flat;
  logic [N-1:0]   rcv_val;
  logic [N-1:0]   rcv_rdy;
  logic [31:0]    rcv_src;
  logic [31:0]    rcv_tag;
  logic [63:0]    rcv_msg;
  logic [15:0]    drop_count;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: message slot, fairness pointer, drop tally.
  bit          m_full;
  int          m_dst, m_src, m_ptr;
  logic [31:0] m_tag;
  logic [63:0] m_msg;
  logic [15:0] m_drops;
  int          last_grant;

  always #5 clk = ~clk;

  assign snd_dst_flat = {d_dst[3], d_dst[2], d_dst[1], d_dst[0]};
  assign snd_tag_flat = {d_tag[3], d_tag[2], d_tag[1], d_tag[0]};
  assign snd_msg_flat = {d_msg[3], d_msg[2], d_msg[1], d_msg[0]};

  bus_interconnect #(.NODES(N), .DROP_CNT_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .snd_val_i    (snd_val),
    .snd_ack_o    (snd_ack),
    .snd_dst_i    (snd_dst_flat),
    .snd_tag_i    (snd_tag_flat),
    .snd_msg_i    (snd_msg_flat),
    .rcv_val_o    (rcv_val),
    .rcv_rdy_i    (rcv_rdy),
    .rcv_src_o    (rcv_src),
    .rcv_tag_o    (rcv_tag),
    .rcv_msg_o    (rcv_msg),
    .drop_count_o (drop_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full  = 0;
    m_dst   = 0;
    m_src   = 0;
    m_ptr   = 0;
    m_tag   = '0;
    m_msg   = '0;
    m_drops = '0;
  endtask

  task automatic set_req(input int n, input int dst);
    snd_val[n] = 1'b1;
    d_dst[n]   = dst;
    d_tag[n]   = $urandom;
    d_msg[n]   = {$urandom, $urandom};
  endtask

  // One clock: predict this cycle's outputs, compare, then advance the model.
  task automatic step();
    logic [N-1:0] exp_ack, exp_rv;
    bit drain, accept;
    int g;
    #1;
    exp_rv = m_full ? (N'(1) << m_dst) : '0;
    drain  = m_full && rcv_rdy[m_dst];
    accept = !m_full || drain;
    g = -1;
    if (accept) begin
      for (int k = 0; k < N; k++) begin
        if (g < 0 && snd_val[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
    end
    exp_ack = (g >= 0) ? (N'(1) << g) : '0;
    chk("ack", 64'(snd_ack), 64'(exp_ack));
    chk("rcv_val", 64'(rcv_val), 64'(exp_rv));
    chk("src", 64'(rcv_src), 64'(m_src));
    chk("tag", 64'(rcv_tag), 64'(m_tag));
    chk("msg", rcv_msg, m_msg);
    chk("drops", 64'(drop_count), 64'(m_drops));
    $display("cyc t=%0t val=%b ack=%b rdy=%b rcv_val=%b src=%0d drops=%0d",
             $time, snd_val, snd_ack, rcv_rdy, rcv_val, rcv_src, drop_count);
    last_grant = g;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (drain) m_full = 0;
      if (g >= 0) begin
        m_ptr = (g + 1) % N;
        if (d_dst[g] < N) begin
          m_full = 1;
          m_dst  = int'(d_dst[g]);
          m_src  = g;
          m_tag  = d_tag[g];
          m_msg  = d_msg[g];
        end else if (m_drops != 16'hFFFF) begin
          m_drops = m_drops + 1'b1;
        end
      end
    end
    #1;
    if (g >= 0) snd_val[g] = 1'b0;
  endtask

  // mode 0: no refill, 1: all nodes keep requesting routable dsts,
  // 2: random requests/readiness incl. unroutable, 3: node 3 floods dst 7
  task automatic run(input int cycles, input int mode);
    for (int c = 0; c < cycles; c++) begin
      if (mode == 2) begin
        rcv_rdy = N'($urandom);
        for (int n = 0; n < N; n++)
          if (!snd_val[n] && $urandom_range(0, 1) == 1) set_req(n, $urandom_range(0, 5));
      end
      step();
      if (last_grant >= 0) begin
        if (mode == 1) set_req(last_grant, $urandom_range(0, N - 1));
        if (mode == 3) set_req(3, 7);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    snd_val = '0;
    rcv_rdy = '0;
    for (int n = 0; n < N; n++) begin
      d_dst[n] = '0;
      d_tag[n] = '0;
      d_msg[n] = '0;
    end
    repeat (3) @(posedge clk);
    model_reset();
    #1 rst = 1'b0;
    #1;
    chk("reset_ack", 64'(snd_ack), 64'h0);
    chk("reset_rcv_val", 64'(rcv_val), 64'h0);
    chk("reset_drops", 64'(drop_count), 64'h0);
    chk("reset_msg", rcv_msg, 64'h0);

    // Single message: node 1 to node 2.
    rcv_rdy = '1;
    snd_val[1] = 1'b1;
    d_dst[1] = 2;
    d_tag[1] = 32'hA5;
    d_msg[1] = 64'h1122334455667788;
    #1 chk("t1_ack", 64'(snd_ack), 64'h2);
    step();
    #1;
    chk("t1_rcv_val", 64'(rcv_val), 64'h4);
    chk("t1_src", 64'(rcv_src), 64'h1);
    chk("t1_tag", 64'(rcv_tag), 64'hA5);
    chk("t1_msg", rcv_msg, 64'h1122334455667788);
    step();

    // Everyone requesting, everyone ready.
    for (int n = 0; n < N; n++) set_req(n, $urandom_range(0, N - 1));
    run(9, 1);
    snd_val = '0;
    run(2, 0);

    // Back-pressure on node 3 blocks node 2 until ready returns.
    rcv_rdy = 4'b0111;
    set_req(0, 3);
    step();
    set_req(2, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("stall_ack", 64'(snd_ack), 64'h0);
      chk("stall_rcv_val", 64'(rcv_val), 64'h8);
      step();
    end
    rcv_rdy = '1;
    #1 chk("unstall_ack", 64'(snd_ack), 64'h4);
    step();
    run(2, 0);

    // Unroutable destination.
    set_req(3, 7);
    step();
    #1;
    chk("drop_rcv_val", 64'(rcv_val), 64'h0);
    chk("drop_count1", 64'(drop_count), 64'h1);

    // Loopback.
    set_req(2, 2);
    step();
    #1;
    chk("loop_rcv_val", 64'(rcv_val), 64'h4);
    chk("loop_src", 64'(rcv_src), 64'h2);
    step();

    // Random traffic.
    run(300, 2);
    snd_val = '0;
    rcv_rdy = '1;
    run(2, 0);

    // Reset while holding an undeliverable message.
    rcv_rdy = '0;
    set_req(0, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    chk("rst_rcv_val", 64'(rcv_val), 64'h0);
    chk("rst_drops", 64'(drop_count), 64'h0);
    rcv_rdy = '1;
    for (int n = 0; n < N; n++) set_req(n, $urandom_range(0, N - 1));
    #1 chk("rst_first_grant", 64'(snd_ack), 64'h1);
    run(8, 1);
    snd_val = '0;
    run(2, 0);

    // Drop counter saturation.
    set_req(3, 7);
    run(65537, 3);
    snd_val = '0;
    #1 chk("drop_saturated", 64'(drop_count), 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
